// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the carry-lookahead subtractor:
//   CLA_DEFAULT_WIDTH : default operand / difference width
//   cla_state_e       : controller states (IDLE, CALC, DONE)
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } cla_state_e;

endpackage

// File: rtl/cla_sub_core.sv
// ---------------------------------------------------------------------------
// cla_sub_core
// Purely combinational a - b, computed as a + ~b + 1 with carry-lookahead.
// Every carry is a flat sum of generate/propagate products, so no carry
// depends on a previously computed carry.
// Ports:
//   a    [WIDTH-1:0] in  : minuend
//   b    [WIDTH-1:0] in  : subtrahend
//   diff [WIDTH-1:0] out : (a - b) mod 2^WIDTH
//   cout             out : final carry (0 means a borrow occurred)
// ---------------------------------------------------------------------------
module cla_sub_core import cla_pkg::*; #(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[1]g[0] | p[i]..p[0]cin,
    // with cin = 1 for the two's-complement increment.
    always_comb begin
        logic carry;
        logic term;
        carry = 1'b0;
        term  = 1'b0;
        c     = '0;
        c[0]  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry = 1'b1;
            for (int k = 0; k <= i; k++) begin
                carry = carry & p[k];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                carry = carry | term;
            end
            c[i+1] = carry;
        end
    end

    assign diff = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/cla_subtractor.sv
// ---------------------------------------------------------------------------
// cla_subtractor
// Valid/ready wrapped unsigned subtractor. An accepted operand pair is
// registered, the difference is computed in CALC by cla_sub_core and
// presented in DONE until the consumer takes it. A new pair may be accepted
// in the same cycle the result is taken, giving one result every 2 cycles.
//
// Optional feature (macro CLA_SUB_SATURATE_EN): when defined, diff is clamped
// to 0 whenever a borrow occurs; bout and zero still describe the raw
// difference. When undefined, diff wraps mod 2^WIDTH.
//
//   state | meaning
//   IDLE  | empty, waiting for an operand pair
//   CALC  | operands held in a_q/b_q, result being registered
//   DONE  | result valid, waiting for out_ready
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake, a and b captured on transfer
//   a, b [WIDTH-1:0]    : unsigned minuend / subtrahend
//   out_valid/out_ready : result handshake
//   diff [WIDTH-1:0]    : difference
//   bout                : borrow out (a < b)
//   zero                : raw difference is zero
// ---------------------------------------------------------------------------
module cla_subtractor import cla_pkg::*; #(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    cla_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] core_diff;
    logic             core_cout;
    logic             core_bout;
    logic             core_zero;
    logic             accept;

    cla_sub_core #(.WIDTH(WIDTH)) u_core (
        .a    (a_q),
        .b    (b_q),
        .diff (core_diff),
        .cout (core_cout)
    );

    assign core_bout = ~core_cout;
    assign core_zero = (core_diff == '0);

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef CLA_SUB_SATURATE_EN
                diff_d = core_bout ? '0 : core_diff;
`else
                diff_d = core_diff;
`endif
                bout_d  = core_bout;
                zero_d  = core_zero;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_cla_subtractor.sv
module tb_cla_subtractor;

    localparam int W = 5;

`ifdef CLA_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    cla_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        int           cyc;
    } res_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    res_t hs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records each result handshake shortly before the edge that completes it.
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid && out_ready) begin
            hs_q.push_back('{diff: diff, bout: bout, zero: zero, cyc: cyc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with the block idle.
    task automatic run_txn(input vec_t v);
        a         = v.a;
        b         = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("txn in_ready before accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("txn out_valid one edge after accept", out_valid, 0);
        chk("txn in_ready in calc", in_ready, 0);
        @(negedge clk);
        chk("txn out_valid", out_valid, 1);
        chk("txn diff", diff, v.diff);
        chk("txn bout", bout, v.bout);
        chk("txn zero", zero, v.zero);
        @(negedge clk);
        chk("txn out_valid after transfer", out_valid, 0);
    endtask

    vec_t vecs[7];
    vec_t v;
    vec_t b2b[3];
    int   n_before;
    int   idx;
    bit   acc;

    initial begin
        vecs[0] = '{a: 5'd5,  b: 5'd3,  diff: 5'd2,  bout: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 5'd0,  b: 5'd1,  diff: SAT ? 5'd0 : 5'd31, bout: 1'b1, zero: 1'b0};
        vecs[2] = '{a: 5'd16, b: 5'd16, diff: 5'd0,  bout: 1'b0, zero: 1'b1};
        vecs[3] = '{a: 5'd31, b: 5'd0,  diff: 5'd31, bout: 1'b0, zero: 1'b0};
        vecs[4] = '{a: 5'd0,  b: 5'd0,  diff: 5'd0,  bout: 1'b0, zero: 1'b1};
        vecs[5] = '{a: 5'd1,  b: 5'd31, diff: SAT ? 5'd0 : 5'd2,  bout: 1'b1, zero: 1'b0};
        vecs[6] = '{a: 5'd19, b: 5'd6,  diff: 5'd13, bout: 1'b0, zero: 1'b0};

        b2b[0] = '{a: 5'd7,  b: 5'd2,  diff: 5'd5,  bout: 1'b0, zero: 1'b0};
        b2b[1] = '{a: 5'd2,  b: 5'd7,  diff: SAT ? 5'd0 : 5'd27, bout: 1'b1, zero: 1'b0};
        b2b[2] = '{a: 5'd31, b: 5'd31, diff: 5'd0,  bout: 1'b0, zero: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #2;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset zero", zero, 0);

        // First pair presented immediately so it is taken on the first edge
        // after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end

        // Stalled consumer: result must hold, new data must be ignored.
        a         = 5'd21;
        b         = 5'd11;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        a = 5'd30;
        b = 5'd1;
        @(negedge clk);
        n_before = hs_q.size();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall out_valid", out_valid, 1);
            chk("stall diff", diff, 10);
            chk("stall bout", bout, 0);
            chk("stall in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall out_valid after release", out_valid, 0);
        chk("stall transfer count", hs_q.size(), n_before + 1);
        chk("stall transferred diff", hs_q[hs_q.size()-1].diff, 10);

        // Reset pulse while (9,4) is in CALC.
        a        = 5'd9;
        b        = 5'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset in_ready", in_ready, 1);
        chk("midreset diff", diff, 0);
        chk("midreset bout", bout, 0);
        chk("midreset zero", zero, 0);
        n_before = hs_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("postreset out_valid", out_valid, 0);
            @(negedge clk);
        end
        chk("postreset no transfer", hs_q.size(), n_before);
        v = '{a: 5'd3, b: 5'd1, diff: 5'd2, bout: 1'b0, zero: 1'b0};
        run_txn(v);

        // Back-to-back stream with in_valid held.
        hs_q.delete();
        idx       = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && idx < 3; t++) begin
            a        = b2b[idx].a;
            b        = b2b[idx].b;
            in_valid = 1'b1;
            #1;
            acc = in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("b2b pairs accepted", idx, 3);
        repeat (4) @(negedge clk);
        chk("b2b result count", hs_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < hs_q.size()) begin
                chk("b2b diff", hs_q[i].diff, b2b[i].diff);
                chk("b2b bout", hs_q[i].bout, b2b[i].bout);
                chk("b2b zero", hs_q[i].zero, b2b[i].zero);
                if (i > 0) chk("b2b spacing", hs_q[i].cyc - hs_q[i-1].cyc, 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
